// File: rtl/maze_timer_display.sv
// maze_timer_display
//
// Elapsed-time keeper and 4-digit seven-segment driver for the maze game.
// Counts MM:SS in BCD while a run is active and time-multiplexes the value
// onto a common-anode display.
//
// Optional feature macro: PAUSE_BLINK_EN
//   defined   : display blinks (dark on odd sec_ticks) while paused.
//   undefined : display steady in every state.
//
// Parameters:
//   MAX_MIN   highest minute value (1..99); count saturates at MAX_MIN:59.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   sec_tick   one-cycle 1 Hz pulse
//   scan_sq    digit-scan square wave; each rising edge advances the digit
//   start      begin/resume counting (pulse)
//   pause      toggle RUN/PAUSE (pulse)
//   stop       freeze count, maze solved (pulse)
//   clear      zero count, back to IDLE (pulse)
//   time_bcd   {min_tens, min_ones, sec_tens, sec_ones}
//   running    high only in RUN
//   saturated  set on a tick at MAX_MIN:59; cleared by clear/rst
//   an         digit enables, active-low, an[3] = min_tens
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low, lit on digit 2 only

module maze_timer_display #(
    parameter int MAX_MIN = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic        scan_sq,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        saturated,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0]  MAX_T    = 4'(MAX_MIN / 10);
    localparam logic [3:0]  MAX_O    = 4'(MAX_MIN % 10);
    localparam logic [15:0] TIME_MAX = {MAX_T, MAX_O, 4'd5, 4'd9};

    state_t      state;
    state_t      nxt;
    logic        sq_p0;
    logic        sq_p1;
    logic        scan_on;
    logic [1:0]  idx;

    // BCD increment with per-digit carry; saturation is handled by the caller.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd9) begin
            so = so + 4'd1;
        end else begin
            so = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mo != 4'd9) begin
                    mo = mo + 4'd1;
                end else begin
                    mo = 4'd0;
                    mt = mt + 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Next state; clear is handled in the register block since it
    // overrides everything below rst.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (stop) nxt = DONE;
                     else if (pause) nxt = PAUSE;
            PAUSE:   if (stop) nxt = DONE;
                     else if (start || pause) nxt = RUN;
            default: nxt = DONE;
        endcase
    end

`ifdef PAUSE_BLINK_EN
    logic blink;

    // Toggles on ticks only while remaining in PAUSE, so the display is lit
    // on the first paused cycle and on return to RUN.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            blink <= 1'b0;
        end else if (state == PAUSE && nxt == PAUSE) begin
            if (sec_tick) blink <= ~blink;
        end else begin
            blink <= 1'b0;
        end
    end
`else
    logic blink;
    assign blink = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= IDLE;
            time_bcd  <= '0;
            running   <= 1'b0;
            saturated <= 1'b0;
        end else begin
            // A tick in RUN counts even when stop/pause arrives the same cycle.
            if (state == RUN && sec_tick) begin
                if (time_bcd == TIME_MAX) saturated <= 1'b1;
                else                      time_bcd  <= bcd_inc(time_bcd);
            end
            state   <= nxt;
            running <= (nxt == RUN);
        end
    end

    // Scan stage: sample scan_sq, detect its rise, step the digit index.
    // The first rise after reset lights index 0 instead of advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_p0   <= 1'b0;
            sq_p1   <= 1'b0;
            scan_on <= 1'b0;
            idx     <= 2'd0;
        end else begin
            sq_p0 <= scan_sq;
            sq_p1 <= sq_p0;
            if (sq_p0 && !sq_p1) begin
                if (!scan_on) scan_on <= 1'b1;
                else          idx     <= idx + 2'd1;
            end
        end
    end

    // Output stage: an/seg/dp registered together so digits switch cleanly.
    always_ff @(posedge clk) begin
        if (rst || !scan_on) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an <= blink ? 4'b1111 : ~(4'b0001 << idx);
            dp <= (idx != 2'd2);
            case (idx)
                2'd0:    seg <= seg_decode(time_bcd[3:0]);
                2'd1:    seg <= seg_decode(time_bcd[7:4]);
                2'd2:    seg <= seg_decode(time_bcd[11:8]);
                default: seg <= (time_bcd[15:12] == 4'd0) ? 7'h7F
                                                          : seg_decode(time_bcd[15:12]);
            endcase
        end
    end

endmodule

// File: tb/tb_maze_timer_display.sv
module tb_maze_timer_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sec_tick = 1'b0, scan_sq = 1'b0;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, clear = 1'b0;

    logic [15:0] time_a, time_b;
    logic        run_a, run_b, sat_a, sat_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int checks = 0;
    int failures = 0;
    bit armed = 0;

    maze_timer_display #(.MAX_MIN(99)) dut_a (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .scan_sq(scan_sq),
        .start(start), .pause(pause), .stop(stop), .clear(clear),
        .time_bcd(time_a), .running(run_a), .saturated(sat_a),
        .an(an_a), .seg(seg_a), .dp(dp_a));

    maze_timer_display #(.MAX_MIN(1)) dut_b (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .scan_sq(scan_sq),
        .start(start), .pause(pause), .stop(stop), .clear(clear),
        .time_bcd(time_b), .running(run_b), .saturated(sat_b),
        .an(an_b), .seg(seg_b), .dp(dp_b));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Time kept as plain seconds; state as small integers
    // 0=IDLE 1=RUN 2=PAUSE 3=DONE.
    int   m_st = 0;
    int   m_secs_a = 0, m_secs_b = 0;
    bit   m_sat_a = 0, m_sat_b = 0;
    bit   m_blk = 0;
    int   m_pos = -1;          // -1 means display not yet started
    bit   m_sq1 = 0, m_sq2 = 0;
    logic [3:0] m_an = 4'hF;
    logic [6:0] m_seg = 7'h7F;
    logic       m_dp = 1'b1;
    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [15:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic model_step();
        int dg [4];
        int nst;
        if (rst) begin
            m_st = 0; m_secs_a = 0; m_secs_b = 0; m_sat_a = 0; m_sat_b = 0;
            m_blk = 0; m_pos = -1; m_sq1 = 0; m_sq2 = 0;
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
            return;
        end
        // display reflects the digit position and time before this edge
        if (m_pos < 0) begin
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
        end else begin
            dg[0] = (m_secs_a % 60) % 10;
            dg[1] = (m_secs_a % 60) / 10;
            dg[2] = (m_secs_a / 60) % 10;
            dg[3] = (m_secs_a / 60) / 10;
            m_an = 4'hF;
            m_an[m_pos] = 1'b0;
            m_seg = (m_pos == 3 && dg[3] == 0) ? 7'h7F : segtab[dg[m_pos]];
            m_dp  = (m_pos != 2);
            if (m_blk) m_an = 4'hF;
        end
        if (m_sq1 && !m_sq2) m_pos = (m_pos < 0) ? 0 : (m_pos + 1) % 4;
        m_sq2 = m_sq1;
        m_sq1 = scan_sq;
        if (clear) begin
            m_st = 0; m_secs_a = 0; m_secs_b = 0; m_sat_a = 0; m_sat_b = 0;
            m_blk = 0;
            return;
        end
        if (m_st == 1 && sec_tick) begin
            if (m_secs_a == 99 * 60 + 59) m_sat_a = 1; else m_secs_a++;
            if (m_secs_b == 1 * 60 + 59)  m_sat_b = 1; else m_secs_b++;
        end
        nst = m_st;
        case (m_st)
            0: if (start) nst = 1;
            1: if (stop) nst = 3; else if (pause) nst = 2;
            2: if (stop) nst = 3; else if (start || pause) nst = 1;
            default: nst = 3;
        endcase
`ifdef PAUSE_BLINK_EN
        if (m_st == 2 && nst == 2) begin
            if (sec_tick) m_blk = ~m_blk;
        end else begin
            m_blk = 0;
        end
`endif
        m_st = nst;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // compare process: every cycle once reset has been applied
    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("time_a",  32'(time_a), 32'(to_bcd(m_secs_a)));
            chk("run_a",   32'(run_a),  32'(m_st == 1));
            chk("sat_a",   32'(sat_a),  32'(m_sat_a));
            chk("time_b",  32'(time_b), 32'(to_bcd(m_secs_b)));
            chk("run_b",   32'(run_b),  32'(m_st == 1));
            chk("sat_b",   32'(sat_b),  32'(m_sat_b));
            chk("an",      32'(an_a),   32'(m_an));
            chk("seg",     32'(seg_a),  32'(m_seg));
            chk("dp",      32'(dp_a),   32'(m_dp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p, input logic st,
                         input logic c, input logic t);
        start = s; pause = p; stop = st; clear = c; sec_tick = t;
        cyc(1);
        start = 0; pause = 0; stop = 0; clear = 0; sec_tick = 0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        repeat (n) pulse(0, 0, 0, 0, 1);
    endtask

    task automatic scan_pulse();
        scan_sq = 1; cyc(2);
        scan_sq = 0; cyc(2);
    endtask

    initial begin
        bit found;
        cyc(3);
        rst = 0;
        armed = 1;
        cyc(1);
        chk("rst_time", 32'(time_a), 32'h0);
        chk("rst_an",   32'(an_a),   32'hF);
        chk("rst_seg",  32'(seg_a),  32'h7F);
        chk("rst_dp",   32'(dp_a),   32'h1);
        chk("rst_run",  32'(run_a),  32'h0);

        // start, 75 seconds, then scan all four digits
        pulse(1, 0, 0, 0, 0);
        ticks(75);
        chk("t75_time", 32'(time_a), 32'h0115);
        chk("t75_run",  32'(run_a),  32'h1);
        scan_pulse();
        chk("scan0_an", 32'(an_a), 32'hE); chk("scan0_seg", 32'(seg_a), 32'h12);
        scan_pulse();
        chk("scan1_an", 32'(an_a), 32'hD); chk("scan1_seg", 32'(seg_a), 32'h79);
        scan_pulse();
        chk("scan2_an", 32'(an_a), 32'hB); chk("scan2_dp", 32'(dp_a), 32'h0);
        scan_pulse();
        chk("scan3_an", 32'(an_a), 32'h7); chk("scan3_seg", 32'(seg_a), 32'h7F);

        // MAX_MIN=1 instance saturates; main instance keeps counting
        ticks(44);
        chk("b_159_time", 32'(time_b), 32'h0159);
        chk("b_159_sat",  32'(sat_b),  32'h0);
        ticks(1);
        chk("b_sat_time", 32'(time_b), 32'h0159);
        chk("b_sat_sat",  32'(sat_b),  32'h1);
        chk("a_200_time", 32'(time_a), 32'h0200);
        chk("b_sat_run",  32'(run_b),  32'h1);
        ticks(479);
        chk("a_959_time", 32'(time_a), 32'h0959);
        ticks(1);
        chk("a_1000_time", 32'(time_a), 32'h1000);
        chk("a_1000_sat",  32'(sat_a),  32'h0);

        // pause ignores ticks; tick+stop counts then freezes
        pulse(0, 0, 0, 1, 0);
        chk("clr_time", 32'(time_a), 32'h0);
        chk("clr_satb", 32'(sat_b),  32'h0);
        pulse(1, 0, 0, 0, 0);
        ticks(9);
        pulse(0, 1, 0, 0, 0);
        chk("pause_run", 32'(run_a), 32'h0);
        ticks(5);
        chk("pause_time", 32'(time_a), 32'h0009);
        pulse(0, 1, 0, 0, 0);
        chk("resume_run", 32'(run_a), 32'h1);
        pulse(0, 0, 1, 0, 1);
        chk("stop_time", 32'(time_a), 32'h0010);
        chk("stop_run",  32'(run_a),  32'h0);
        pulse(1, 0, 0, 0, 0);
        chk("done_start_run", 32'(run_a), 32'h0);
        ticks(1);
        chk("done_time", 32'(time_a), 32'h0010);

        // clear wins over start in the same cycle
        pulse(0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0);
        ticks(30);
        chk("t30_time", 32'(time_a), 32'h0030);
        pulse(1, 0, 0, 1, 0);
        chk("clrstart_time", 32'(time_a), 32'h0);
        chk("clrstart_run",  32'(run_a),  32'h0);

        // blink behaviour in PAUSE
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        chk("pause_entry_an", 32'(an_a == 4'hF), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            ticks(1);
            cyc(1);
`ifdef PAUSE_BLINK_EN
            chk("blink_an", 32'(an_a == 4'hF), 32'((i % 2) == 1));
`else
            chk("steady_an", 32'(an_a == 4'hF), 32'h0);
`endif
        end
        pulse(0, 1, 0, 0, 0);
        cyc(1);
        chk("resume_lit", 32'(an_a == 4'hF), 32'h0);

        // reset in the middle of a scan
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            scan_pulse();
            if (an_a == 4'b1011) found = 1;
        end
        chk("reach_idx2", 32'(found), 32'h1);
        rst = 1;
        cyc(1);
        chk("midrst_an",  32'(an_a),  32'hF);
        chk("midrst_seg", 32'(seg_a), 32'h7F);
        rst = 0;
        cyc(1);
        scan_pulse();
        chk("restart_an", 32'(an_a), 32'hE);
        chk("restart_seg", 32'(seg_a), 32'h40);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
